// File: rtl/imem_loader.sv
// Byte-stream program loader: length-prefixed bytes are packed big-endian into
// 32-bit words and written to consecutive imem addresses while the CPU is held.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_reg, state_next;
  logic [15:0] len_reg, len_next;
  logic [1:0]  k_reg, k_next;
  logic [15:0] wl_reg, wl_next;
  logic [31:0] addr_reg, addr_next;

  logic        in_ready_reg, in_ready_next;
  logic        we_reg, we_next;
  logic        hold_reg, hold_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] count_inc;

  assign xfer      = in_valid & in_ready_reg;
  assign len_full  = {len_reg[15:8], in_data};
  assign count_inc = wl_reg + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= 16'd0;
      k_reg        <= 2'd0;
      wl_reg       <= 16'd0;
      addr_reg     <= BASE_ADDR;
      in_ready_reg <= 1'b0;
      we_reg       <= 1'b0;
      hold_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      k_reg        <= k_next;
      wl_reg       <= wl_next;
      addr_reg     <= addr_next;
      in_ready_reg <= in_ready_next;
      we_reg       <= we_next;
      hold_reg     <= hold_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    k_next     = k_reg;
    wl_next    = wl_reg;
    addr_next  = addr_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_LEN_HI;
          wl_next    = 16'd0;
          k_next     = 2'd0;
          addr_next  = BASE_ADDR;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_next   = {in_data, len_reg[7:0]};
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_next = len_full;
          if (len_full == 16'd0)
            state_next = S_DONE;
          else if ({1'b0, len_full} > DEPTH_W)
            state_next = S_ERROR;
          else
            state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          k_next = k_reg + 2'd1;
          if (k_reg == 2'd3)
            state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address tracks BASE_ADDR + 4*words_loaded; wraps naturally at 2^32.
        wl_next    = count_inc;
        addr_next  = addr_reg + 32'd4;
        state_next = (count_inc == len_reg) ? S_DONE : S_DATA;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in-state.
  always_comb begin
    in_ready_next = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                    (state_next == S_DATA);
    we_next       = (state_next == S_WRITE);
    busy_next     = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                    (state_next == S_DATA)   || (state_next == S_WRITE);
    done_next     = (state_next == S_DONE);
    error_next    = (state_next == S_ERROR);
    hold_next     = (state_next != S_DONE);
  end

  // One byte lane per word byte; byte k lands in bits [31-8k -: 8].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          lane_reg <= 8'd0;
        else if ((state_reg == S_DATA) && xfer && (k_reg == 2'(gi)))
          lane_reg <= in_data;
      end
    end
  endgenerate

  assign imem_wdata   = {g_lane[0].lane_reg, g_lane[1].lane_reg,
                         g_lane[2].lane_reg, g_lane[3].lane_reg};
  assign imem_addr    = addr_reg;
  assign in_ready     = in_ready_reg;
  assign imem_we      = we_reg;
  assign cpu_hold     = hold_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = wl_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: one task per scenario, inline checks,
// write port captured by a negedge monitor.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (wr_count < 64) begin
        wr_addr[wr_count] = imem_addr;
        wr_data[wr_count] = imem_wdata;
      end
      wr_count++;
      $display("write addr=%08h data=%08h", imem_addr, imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits (bounded) for in_ready, then presents one byte for exactly one transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    in_data  = 8'ha5;
    repeat (gap) @(negedge clock);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b want 1 (byte %02h)", in_ready, b);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 8'h5a;
    $display("byte %02h accepted", b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %08h want 00000000", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %08h want 00000000", imem_wdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL reset_wl: got %0d want 0", words_loaded); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_start_with_byte();
    start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL swb_state: busy=%b in_ready=%b want 1 1", busy, in_ready); end
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h11223344 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL swb_write: we=%b addr=%08h data=%08h want 1 00000000 11223344", imem_we, imem_addr, imem_wdata); end
    @(negedge clock);
    checks++; if (done !== 1'b1 || words_loaded !== 16'd1) begin errors++; $display("FAIL swb_done: done=%b wl=%0d want 1 1", done, words_loaded); end
  endtask

  task automatic test_basic();
    int base;
    base = wr_count;
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_start: done=%b hold=%b busy=%b want 0 1 1", done, cpu_hold, busy); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("FAIL basic_wl_clear: got %0d want 0", words_loaded); end
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h24, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h24080005) begin
      errors++; $display("FAIL basic_w0: we=%b addr=%08h data=%08h want 1 00000000 24080005", imem_we, imem_addr, imem_wdata); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_write_ready: got %b want 0", in_ready); end
    @(negedge clock);
    checks++; if (imem_we !== 1'b0 || words_loaded !== 16'd1) begin
      errors++; $display("FAIL basic_after_w0: we=%b wl=%0d want 0 1", imem_we, words_loaded); end
    send_byte(8'h01, 0); send_byte(8'h09, 0); send_byte(8'h50, 0); send_byte(8'h20, 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'h01095020) begin
      errors++; $display("FAIL basic_w1: we=%b addr=%08h data=%08h want 1 00000004 01095020", imem_we, imem_addr, imem_wdata); end
    @(negedge clock);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd2 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_done: done=%b hold=%b wl=%0d busy=%b rdy=%b want 1 0 2 0 0", done, cpu_hold, words_loaded, busy, in_ready); end
    checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d want 2", wr_count - base); end
  endtask

  task automatic test_zero_len();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL zero_hold_before: got %b want 1", cpu_hold); end
    send_byte(8'h00, 0);
    checks++; if (cpu_hold !== 1'b0 || done !== 1'b1 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL zero_done: hold=%b done=%b wl=%0d want 0 1 0", cpu_hold, done, words_loaded); end
    repeat (2) @(negedge clock);
    checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL zero_nwrites: got %0d want 0", wr_count - base); end
  endtask

  task automatic test_error();
    int base;
    base = wr_count;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    repeat (3) @(negedge clock);
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_state: err=%b hold=%b rdy=%b done=%b busy=%b want 1 1 0 0 0", error, cpu_hold, in_ready, done, busy); end
    checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL err_nwrites: got %0d want 0", wr_count - base); end
  endtask

  task automatic test_boundary_and_reset();
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL recover: err=%b busy=%b want 0 1", error, busy); end
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    checks++; if (error !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL len256: err=%b rdy=%b busy=%b want 0 1 1", error, in_ready, busy); end
    send_byte(8'hde, 0); send_byte(8'had, 0);
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1 || imem_we !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctl: rdy=%b busy=%b hold=%b we=%b want 0 0 1 0", in_ready, busy, cpu_hold, imem_we); end
    checks++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL async_reset_data: addr=%08h data=%08h wl=%0d want 0 0 0", imem_addr, imem_wdata, words_loaded); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hca, 0); send_byte(8'hfe, 0); send_byte(8'hba, 0); send_byte(8'hbe, 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'hcafebabe) begin
      errors++; $display("FAIL reload_w0: we=%b addr=%08h data=%08h want 1 00000000 cafebabe", imem_we, imem_addr, imem_wdata); end
    @(negedge clock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done); end
  endtask

  task automatic test_gaps();
    int base;
    logic [7:0]  bytes [14];
    logic [31:0] exp_d [3];
    bytes = '{8'h00, 8'h03, 8'h3c, 8'h01, 8'h00, 8'h00, 8'h8c, 8'h22,
              8'h00, 8'h04, 8'hac, 8'h23, 8'h00, 8'h08};
    exp_d = '{32'h3c010000, 32'h8c220004, 32'hac230008};
    base = wr_count;
    pulse_start();
    for (int i = 0; i < 14; i++) send_byte(bytes[i], int'($urandom_range(0, 7)));
    repeat (2) @(negedge clock);
    checks++; if (wr_count - base !== 3) begin errors++; $display("FAIL gaps_nwrites: got %0d want 3", wr_count - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[base+i] !== 32'(4*i) || wr_data[base+i] !== exp_d[i]) begin
        errors++; $display("FAIL gaps_w%0d: addr=%08h data=%08h want %08h %08h", i, wr_addr[base+i], wr_data[base+i], 32'(4*i), exp_d[i]); end
    end
    checks++; if (done !== 1'b1 || words_loaded !== 16'd3) begin errors++; $display("FAIL gaps_done: done=%b wl=%0d want 1 3", done, words_loaded); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 16'd0) begin
      errors++; $display("FAIL b2b_restart: done=%b hold=%b wl=%0d want 0 1 0", done, cpu_hold, words_loaded); end
    send_byte(8'h00, 0);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    pulse_start();
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h01020304) begin
      errors++; $display("FAIL b2b_w0: we=%b addr=%08h data=%08h want 1 00000000 01020304", imem_we, imem_addr, imem_wdata); end
    pulse_start();
    send_byte(8'ha1, 0); send_byte(8'hb2, 0); send_byte(8'hc3, 0); send_byte(8'hd4, 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'ha1b2c3d4) begin
      errors++; $display("FAIL b2b_w1: we=%b addr=%08h data=%08h want 1 00000004 a1b2c3d4", imem_we, imem_addr, imem_wdata); end
    @(negedge clock);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
      errors++; $display("FAIL b2b_done: done=%b hold=%b wl=%0d want 1 0 2", done, cpu_hold, words_loaded); end
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_again: done=%b hold=%b busy=%b want 0 1 1", done, cpu_hold, busy); end
  endtask

  initial begin
    test_reset();
    test_start_with_byte();
    test_basic();
    test_zero_len();
    test_error();
    test_boundary_and_reset();
    test_gaps();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
